mcu_memcpy: RTL
===============

Name: mcu_memcpy

Overview:
- Request initiator for the SNES-side master FSM's MCU memory port (the rrq/wrq/rdy handshake that mcu_cmd drives today).
- Performs autonomous block copy (ROM/PSRAM to ROM/PSRAM) or block fill without per-byte SPI traffic.
- Sits beside mcu_cmd. Its rrq/wrq/addr/dout are OR-muxed into the arbiter's request inputs when `busy` is high.
- The arbiter's read data (MCU_DINr) returns on `din`.

Parameters:
- ADDR_W, 24, width of memory byte addresses
- LEN_W, 16, width of transfer length counter
- GUARD, 1, cycles after a request pulse during which `rdy` is ignored (the arbiter drops rdy one cycle after rrq/wrq)

Ports:
- clk  in  1  system clock (CLK2 domain)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, latches configuration; ignored while busy
- mode  in  1  0 = copy src->dst, 1 = fill dst with fill_data
- src_addr  in  ADDR_W  copy source start byte address
- dst_addr  in  ADDR_W  destination start byte address
- len  in  LEN_W  byte count; 0 = no transfer
- fill_data  in  8  fill byte
- abort  in  1  one-cycle pulse, terminates transfer
- rrq  out  1  one-cycle read request pulse to arbiter
- wrq  out  1  one-cycle write request pulse to arbiter
- addr  out  ADDR_W  request address, stable from the request pulse until rdy returns
- dout  out  8  write data, stable from wrq until rdy returns
- rdy  in  1  arbiter ready; low while a request is pending
- din  in  8  read data, valid when rdy rises after rrq
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- aborted  out  1  sticky flag, set on abort, cleared by the next start

Behaviour:
- Reset values:
  - rrq = wrq = busy = done = aborted = 0
  - addr = 0, dout = 0
  - FSM in IDLE, counters 0
- States:
  - IDLE
  - RD_REQ, RD_GUARD, RD_WAIT
  - WR_REQ, WR_GUARD, WR_WAIT
  - FIN
- IDLE:
  - On start with len != 0: latch all inputs, set remaining = len, busy = 1, clear aborted.
    - mode = 0 goes to RD_REQ.
    - mode = 1 goes to WR_REQ with dout = fill_data.
  - On start with len == 0: go to FIN. No rrq/wrq is ever issued.
- RD_REQ:
  - Present addr = src pointer and assert rrq for exactly one cycle (only if rdy = 1).
  - Then go to RD_GUARD.
  - If rdy = 0, wait in RD_REQ; never issue while the arbiter is busy.
- RD_GUARD: wait GUARD cycles, then go to RD_WAIT.
- RD_WAIT:
  - On rdy = 1: capture din into dout, increment the src pointer, go to WR_REQ.
- WR_REQ:
  - Present addr = dst pointer and assert wrq for one cycle (only if rdy = 1).
  - Then go to WR_GUARD, then to WR_WAIT.
- WR_WAIT, on rdy = 1:
  - Increment the dst pointer and decrement remaining.
  - If remaining was 1, go to FIN.
  - Otherwise go to RD_REQ (copy) or WR_REQ (fill).
- FIN: pulse done for one cycle, busy = 0, return to IDLE.
- Throughput: copy = 2 arbiter transactions per byte; fill = 1.
- Pointers are ADDR_W-bit and wrap modulo 2^ADDR_W (0xFFFFFF + 1 = 0x000000). No masking is applied here; mapping and masking are the arbiter's concern.
- Overlapping regions: strictly ascending byte order. No memmove semantics.
- abort:
  - In IDLE or FIN: ignored.
  - In any REQ state: go to FIN immediately without issuing.
  - In GUARD/WAIT states: finish the outstanding transaction (wait for rdy = 1, do not drop it), then go to FIN.
  - In all accepted cases, set aborted = 1.
- Simultaneous events:
  - start while busy: ignored.
  - start and abort in the same cycle in IDLE: start wins and abort is ignored.
  - rdy already high at the request cycle: still honour GUARD before sampling.
- rrq and wrq are never high together, and never high in consecutive cycles.
- Reset mid-transfer: all state cleared asynchronously, no done pulse. The outstanding arbiter transaction completes on its own.

Decomposition:
- Shared package (mcu_if_pkg): ADDR_W, the one-hot state encoding constants (same one-hot style as the master FSM), GUARD default.
- One natural sub-module, mcu_req_port: drives a single request pulse, the GUARD count and the rdy-wait, reporting `xfer_done`. The top FSM instantiates it once, shared by the read and write phases.

Test Plan:
- Copy: src = 0x000100, dst = 0x200000, len = 4, memory model rdy latency 8 cycles. Requires:
  - Exact sequence rrq@100, wrq@200000, rrq@101 … wrq@200003 (8 transactions).
  - Destination bytes equal the source bytes.
  - Exactly one done pulse; busy low afterwards.
- Fill: dst = 0x00FFFE, len = 3, fill_data = 0xA5. Requires writes at 0x00FFFE, 0x00FFFF, 0x010000, all 0xA5, and no rrq.
- Wrap: copy src = 0xFFFFFF, dst = 0x000010, len = 2. Requires the second read at 0x000000.
- len = 0: start yields done in ≤ 2 cycles, with zero rrq/wrq pulses.
- Abort during RD_WAIT of byte 2 (len = 10):
  - Outstanding read completes, no further requests, done pulses, aborted = 1.
  - The next start clears aborted.
- Protocol checker:
  - rdy held low for 50 cycles before start: no request until rdy = 1.
  - rdy already high when rrq is issued: rdy is not sampled in the guard cycle.
  - Async reset mid-WR_WAIT: all outputs are 0 immediately.

Source files
------------

// File: rtl/mcu_if_pkg.sv
// Shared constants and state encodings for the MCU memory-port request initiators.
package mcu_if_pkg;

    localparam int MCU_ADDR_W = 24;
    localparam int MCU_LEN_W  = 16;
    // Cycles after a request pulse where rdy is still stale from the arbiter.
    localparam int MCU_GUARD  = 1;

    // One-hot block-copy FSM, same style as the SNES-side master FSM.
    typedef enum logic [7:0] {
        S_IDLE     = 8'b0000_0001,
        S_RD_REQ   = 8'b0000_0010,
        S_RD_GUARD = 8'b0000_0100,
        S_RD_WAIT  = 8'b0000_1000,
        S_WR_REQ   = 8'b0001_0000,
        S_WR_GUARD = 8'b0010_0000,
        S_WR_WAIT  = 8'b0100_0000,
        S_FIN      = 8'b1000_0000
    } state_e;

    // One-hot request-port sequencing.
    typedef enum logic [2:0] {
        P_IDLE  = 3'b001,
        P_GUARD = 3'b010,
        P_WAIT  = 3'b100
    } port_e;

endpackage

// File: rtl/mcu_memcpy_if.sv
// Arbiter request bus seen from the memcpy engine (master) and the arbiter (slave).
interface mcu_memcpy_if import mcu_if_pkg::*; #(
    parameter int ADDR_W = MCU_ADDR_W
) ();
    logic              rrq;
    logic              wrq;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    logic              rdy;
    logic [7:0]        din;

    modport master (output rrq, wrq, addr, dout, input  rdy, din);
    modport slave  (input  rrq, wrq, addr, dout, output rdy, din);
endinterface

// File: rtl/mcu_req_port.sv
// Issues one rrq/wrq pulse, masks the stale rdy for GUARD cycles, then waits for rdy.
module mcu_req_port import mcu_if_pkg::*; #(
    parameter int GUARD = MCU_GUARD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick_rd_i,
    input  logic kick_wr_i,
    input  logic rdy_i,
    output logic rrq_o,
    output logic wrq_o,
    output logic guard_end_o,
    output logic xfer_done_o
);
    localparam int CW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    port_e         pst_q;
    logic [CW-1:0] cnt_q;
    logic          rrq_q, wrq_q;

    // Pulse on kick; the pulse cycle is the first guard cycle, rdy only sampled in P_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_q <= P_IDLE;
            cnt_q <= '0;
            rrq_q <= 1'b0;
            wrq_q <= 1'b0;
        end else begin
            rrq_q <= 1'b0;
            wrq_q <= 1'b0;
            case (pst_q)
                P_IDLE: if (kick_rd_i || kick_wr_i) begin
                    rrq_q <= kick_rd_i;
                    wrq_q <= kick_wr_i;
                    cnt_q <= CW'(GUARD);
                    pst_q <= P_GUARD;
                end
                P_GUARD: if (cnt_q == '0) pst_q <= P_WAIT;
                         else             cnt_q <= cnt_q - CW'(1);
                P_WAIT:  if (rdy_i) pst_q <= P_IDLE;
                default: pst_q <= P_IDLE;
            endcase
        end
    end

    assign rrq_o       = rrq_q;
    assign wrq_o       = wrq_q;
    assign guard_end_o = (pst_q == P_GUARD) && (cnt_q == '0);
    assign xfer_done_o = (pst_q == P_WAIT) && rdy_i;
endmodule

// File: rtl/mcu_memcpy.sv
// Autonomous block copy / fill engine on the MCU memory port of the arbiter.
module mcu_memcpy import mcu_if_pkg::*; #(
    parameter int ADDR_W = MCU_ADDR_W,
    parameter int LEN_W  = MCU_LEN_W,
    parameter int GUARD  = MCU_GUARD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [7:0]        fill_data,
    input  logic              abort,
    mcu_memcpy_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    state_e            st_q;
    logic [ADDR_W-1:0] src_q, dst_q, addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [7:0]        dout_q;
    logic              mode_q, abt_pend_q, busy_q, done_q, aborted_q;

    logic kick_rd, kick_wr, rrq_w, wrq_w, guard_end, xfer_done, in_flight, stop_now;

    // Requests only leave while the arbiter is idle and no abort is pending this cycle.
    assign kick_rd   = (st_q == S_RD_REQ) && bus.rdy && !abort;
    assign kick_wr   = (st_q == S_WR_REQ) && bus.rdy && !abort;
    assign in_flight = st_q inside {S_RD_GUARD, S_RD_WAIT, S_WR_GUARD, S_WR_WAIT};
    assign stop_now  = abt_pend_q || abort;

    mcu_req_port #(.GUARD(GUARD)) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .kick_rd_i   (kick_rd),
        .kick_wr_i   (kick_wr),
        .rdy_i       (bus.rdy),
        .rrq_o       (rrq_w),
        .wrq_o       (wrq_w),
        .guard_end_o (guard_end),
        .xfer_done_o (xfer_done)
    );

    // Main sequencer: pointers, remaining count and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            dout_q     <= '0;
            mode_q     <= 1'b0;
            abt_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // An in-flight transaction is never dropped; remember the abort until it lands.
            if (abort && in_flight) begin
                abt_pend_q <= 1'b1;
                aborted_q  <= 1'b1;
            end
            case (st_q)
                S_IDLE: if (start) begin
                    src_q      <= src_addr;
                    dst_q      <= dst_addr;
                    rem_q      <= len;
                    mode_q     <= mode;
                    abt_pend_q <= 1'b0;
                    aborted_q  <= 1'b0;
                    busy_q     <= 1'b1;
                    if (len == '0) st_q <= S_FIN;
                    else if (mode) begin
                        dout_q <= fill_data;
                        st_q   <= S_WR_REQ;
                    end else st_q <= S_RD_REQ;
                end
                S_RD_REQ: if (abort) begin
                    aborted_q <= 1'b1;
                    st_q      <= S_FIN;
                end else if (bus.rdy) begin
                    addr_q <= src_q;
                    st_q   <= S_RD_GUARD;
                end
                S_RD_GUARD: if (guard_end) st_q <= S_RD_WAIT;
                S_RD_WAIT: if (xfer_done) begin
                    dout_q <= bus.din;
                    src_q  <= src_q + ADDR_W'(1);
                    st_q   <= stop_now ? S_FIN : S_WR_REQ;
                end
                S_WR_REQ: if (abort) begin
                    aborted_q <= 1'b1;
                    st_q      <= S_FIN;
                end else if (bus.rdy) begin
                    addr_q <= dst_q;
                    st_q   <= S_WR_GUARD;
                end
                S_WR_GUARD: if (guard_end) st_q <= S_WR_WAIT;
                S_WR_WAIT: if (xfer_done) begin
                    dst_q <= dst_q + ADDR_W'(1);
                    rem_q <= rem_q - LEN_W'(1);
                    if (stop_now || rem_q == LEN_W'(1)) st_q <= S_FIN;
                    else                                st_q <= mode_q ? S_WR_REQ : S_RD_REQ;
                end
                S_FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    st_q   <= S_IDLE;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rrq  = rrq_w;
    assign bus.wrq  = wrq_w;
    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
endmodule
